// File: rtl/rv_pkg.sv
// Shared register-file constants and the write-back source encoding.
package rv_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_AES  = 2'd2
    } wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for buffered write-back entries; pointers carry a wrap bit
// so full/empty fall out of a plain pointer comparison at any power-of-two depth.
module wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/rf_writeback.sv
// Register-file write-port arbiter: ALU results take the slot, buffered AES
// results fill idle slots, and a pending scoreboard flags AES hazards.
module rf_writeback
    import rv_pkg::*;
#(
    parameter int XLEN           = rv_pkg::XLEN,
    parameter int AES_FIFO_DEPTH = 4,
    localparam int CW            = $clog2(AES_FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_wd,
    input  logic                  aes_issue,
    input  logic [REG_ADDR_W-1:0] aes_issue_rd,
    input  logic                  aes_valid,
    output logic                  aes_ready,
    input  logic [REG_ADDR_W-1:0] aes_rd,
    input  logic [XLEN-1:0]       aes_wd,
    input  logic [REG_ADDR_W-1:0] rs1_q,
    input  logic [REG_ADDR_W-1:0] rs2_q,
    output logic                  busy_rs1,
    output logic                  busy_rs2,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_wd,
    output logic [CW-1:0]         fifo_count,
    output logic                  err_waw
);
    localparam int EW = REG_ADDR_W + XLEN;

    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_nxt;
    wb_src_e               sel;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [EW-1:0]         head;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_wd;

    // AES handshake: a result transfers on a cycle where aes_valid && aes_ready;
    // aes_ready depends only on registered occupancy, so a same-cycle pop never frees space.
    assign aes_ready = !fifo_full;
    assign fifo_push = aes_valid && aes_ready && (aes_rd != '0);
    assign head_rd   = head[EW-1:XLEN];
    assign head_wd   = head[XLEN-1:0];

    wb_fifo #(
        .W     (EW),
        .DEPTH (AES_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({aes_rd, aes_wd}),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        sel = WB_NONE;
        if (alu_valid && (alu_rd != '0)) sel = WB_ALU;
        else if (!fifo_empty)            sel = WB_AES;
    end

    assign fifo_pop = (sel == WB_AES);

    // Clear before set so an issue to a register being drained keeps it pending.
    always_comb begin
        pending_nxt = pending;
        if (fifo_pop) pending_nxt[head_rd] = 1'b0;
        if (aes_issue && (aes_issue_rd != '0)) pending_nxt[aes_issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            err_waw <= 1'b0;
            rf_we   <= 1'b0;
            rf_rd   <= '0;
            rf_wd   <= '0;
        end else begin
            pending <= pending_nxt;
            if ((sel == WB_ALU) && pending[alu_rd]) err_waw <= 1'b1;
            case (sel)
                WB_ALU: begin
                    rf_we <= 1'b1;
                    rf_rd <= alu_rd;
                    rf_wd <= alu_wd;
                end
                WB_AES: begin
                    rf_we <= 1'b1;
                    rf_rd <= head_rd;
                    rf_wd <= head_wd;
                end
                default: rf_we <= 1'b0;
            endcase
        end
    end

    assign busy_rs1 = (rs1_q != '0) && pending[rs1_q];
    assign busy_rs2 = (rs2_q != '0) && pending[rs2_q];
endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: queue-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_rf_writeback;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wd;
    logic        aes_issue;
    logic [4:0]  aes_issue_rd;
    logic        aes_valid;
    logic        aes_ready;
    logic [4:0]  aes_rd;
    logic [31:0] aes_wd;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic [2:0]  fifo_count;
    logic        err_waw;

    int n_vec = 0;
    int n_err = 0;
    logic cmp_en = 1'b0;

    rf_writeback #(.XLEN(32), .AES_FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_wd       (alu_wd),
        .aes_issue    (aes_issue),
        .aes_issue_rd (aes_issue_rd),
        .aes_valid    (aes_valid),
        .aes_ready    (aes_ready),
        .aes_rd       (aes_rd),
        .aes_wd       (aes_wd),
        .rs1_q        (rs1_q),
        .rs2_q        (rs2_q),
        .busy_rs1     (busy_rs1),
        .busy_rs2     (busy_rs2),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wd        (rf_wd),
        .fifo_count   (fifo_count),
        .err_waw      (err_waw)
    );

    // Clock
    always #5 clk = ~clk;

    // Register file fed by the write port, for end-to-end read-back.
    logic [31:0] regfile [32];
    always @(posedge clk) if (rf_we) regfile[rf_rd] <= rf_wd;

    // Reference model: AES buffer as a queue of {rd, wd}, pending set as a bit per register.
    logic [36:0] exp_q[$];
    bit   [31:0] mpend;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wd;
    logic        exp_err;
    int          sz0;
    logic [36:0] head;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            mpend   = '0;
            exp_we  = 1'b0;
            exp_rd  = '0;
            exp_wd  = '0;
            exp_err = 1'b0;
        end else begin
            sz0 = exp_q.size();
            if (alu_valid && alu_rd != 0) begin
                if (mpend[alu_rd]) exp_err = 1'b1;
                exp_we = 1'b1;
                exp_rd = alu_rd;
                exp_wd = alu_wd;
            end else if (sz0 > 0) begin
                head   = exp_q.pop_front();
                exp_we = 1'b1;
                exp_rd = head[36:32];
                exp_wd = head[31:0];
                mpend[head[36:32]] = 1'b0;
            end else begin
                exp_we = 1'b0;
            end
            if (aes_valid && sz0 < DEPTH && aes_rd != 0) exp_q.push_back({aes_rd, aes_wd});
            if (aes_issue && aes_issue_rd != 0) mpend[aes_issue_rd] = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare against the model, on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rf_we", {31'b0, rf_we}, {31'b0, exp_we});
            chk("rf_rd", {27'b0, rf_rd}, {27'b0, exp_rd});
            chk("rf_wd", rf_wd, exp_wd);
            chk("fifo_count", {29'b0, fifo_count}, exp_q.size());
            chk("aes_ready", {31'b0, aes_ready}, {31'b0, exp_q.size() < DEPTH});
            chk("err_waw", {31'b0, err_waw}, {31'b0, exp_err});
            chk("busy_rs1", {31'b0, busy_rs1}, {31'b0, rs1_q != 0 && mpend[rs1_q]});
            chk("busy_rs2", {31'b0, busy_rs2}, {31'b0, rs2_q != 0 && mpend[rs2_q]});
        end
    end

    // Driver: inputs change 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_wd = 0;
        aes_issue = 0; aes_issue_rd = 0;
        aes_valid = 0; aes_rd = 0; aes_wd = 0;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        rs1_q = 0;
        rs2_q = 12;
        cmp_en = 1;
        repeat (2) tick();
        rst_n = 1;
        chk("rst_we", {31'b0, rf_we}, 32'd0);
        chk("rst_wd", rf_wd, 32'd0);

        // Reset mid-traffic: buffered entry and pending bit must vanish.
        aes_issue = 1; aes_issue_rd = 9;
        alu_valid = 1; alu_rd = 2; alu_wd = 32'h1111_2222;
        aes_valid = 1; aes_rd = 9; aes_wd = 32'h9999_0000;
        tick();
        aes_issue = 0; aes_valid = 0;
        tick();
        chk("pre_rst_count", {29'b0, fifo_count}, 32'd1);
        rst_n = 0;
        #1;
        chk("mid_rst_we", {31'b0, rf_we}, 32'd0);
        chk("mid_rst_rd", {27'b0, rf_rd}, 32'd0);
        chk("mid_rst_count", {29'b0, fifo_count}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            rs1_q = a[4:0];
            #1;
            chk("rst_busy_rs1", {31'b0, busy_rs1}, 32'd0);
        end
        idle_inputs();
        rs1_q = 10;
        tick();
        rst_n = 1;
        tick();
        chk("rel_ready", {31'b0, aes_ready}, 32'd1);
        chk("rel_we", {31'b0, rf_we}, 32'd0);

        // ALU only: one-cycle latency, then visible in the register file.
        alu_valid = 1; alu_rd = 5; alu_wd = 32'hDEAD_BEEF;
        tick();
        alu_valid = 0;
        chk("alu_we", {31'b0, rf_we}, 32'd1);
        chk("alu_rd", {27'b0, rf_rd}, 32'd5);
        chk("alu_wd", rf_wd, 32'hDEAD_BEEF);
        chk("model_alu_we", {31'b0, exp_we}, 32'd1);
        tick();
        chk("alu_idle_we", {31'b0, rf_we}, 32'd0);
        chk("alu_hold_rd", {27'b0, rf_rd}, 32'd5);
        chk("regfile_x5", regfile[5], 32'hDEAD_BEEF);

        // AES behind three ALU writes.
        aes_issue = 1; aes_issue_rd = 10;
        tick();
        aes_issue = 0;
        chk("aes_busy_set", {31'b0, busy_rs1}, 32'd1);
        tick();
        alu_valid = 1; alu_rd = 6; alu_wd = 32'h6;
        aes_valid = 1; aes_rd = 10; aes_wd = 32'h3AD7_7BB4;
        tick();
        aes_valid = 0; alu_wd = 32'h66;
        tick();
        alu_wd = 32'h666;
        tick();
        alu_valid = 0;
        chk("aes_wait_busy", {31'b0, busy_rs1}, 32'd1);
        chk("aes_wait_rd", {27'b0, rf_rd}, 32'd6);
        chk("aes_wait_count", {29'b0, fifo_count}, 32'd1);
        tick();
        chk("aes_we", {31'b0, rf_we}, 32'd1);
        chk("aes_rd", {27'b0, rf_rd}, 32'd10);
        chk("aes_wd", rf_wd, 32'h3AD7_7BB4);
        chk("aes_busy_clr", {31'b0, busy_rs1}, 32'd0);
        chk("model_aes_wd", exp_wd, 32'h3AD7_7BB4);

        // FIFO full under continuous ALU traffic, then one released slot.
        alu_valid = 1; alu_rd = 1;
        for (int i = 0; i < 4; i++) begin
            alu_wd = 32'hA000 + i;
            aes_valid = 1; aes_rd = 5'(16 + i); aes_wd = 32'h1000 + i;
            tick();
        end
        chk("full_count", {29'b0, fifo_count}, 32'd4);
        chk("full_ready", {31'b0, aes_ready}, 32'd0);
        aes_rd = 21; aes_wd = 32'h1004;
        tick();
        chk("held_count", {29'b0, fifo_count}, 32'd4);
        alu_valid = 0;
        tick();
        chk("slot_pop_rd", {27'b0, rf_rd}, 32'd16);
        chk("slot_pop_wd", rf_wd, 32'h1000);
        chk("slot_count", {29'b0, fifo_count}, 32'd3);
        chk("slot_ready", {31'b0, aes_ready}, 32'd1);
        alu_valid = 1;
        tick();
        chk("refill_count", {29'b0, fifo_count}, 32'd4);
        alu_valid = 0;
        for (int i = 0; i < 6; i++) begin
            aes_rd = 5'(24 + i); aes_wd = 32'h2000 + i;
            tick();
        end
        aes_valid = 0;
        repeat (6) tick();
        chk("wrap_last_rd", {27'b0, rf_rd}, 32'd29);
        chk("wrap_last_wd", rf_wd, 32'h2005);
        chk("wrap_empty", {29'b0, fifo_count}, 32'd0);

        // x0 handling and same-cycle set/clear.
        rs1_q = 7;
        aes_issue = 1; aes_issue_rd = 7;
        tick();
        aes_issue = 0;
        alu_valid = 1; alu_rd = 3; alu_wd = 32'h33;
        aes_valid = 1; aes_rd = 7; aes_wd = 32'h77;
        tick();
        aes_rd = 0; aes_wd = 32'h99;
        tick();
        aes_valid = 0;
        chk("x0_not_counted", {29'b0, fifo_count}, 32'd1);
        alu_rd = 0; alu_wd = 32'hBAD0_0000;
        aes_issue = 1; aes_issue_rd = 7;
        tick();
        aes_issue = 0; alu_valid = 0;
        chk("x0_pop_rd", {27'b0, rf_rd}, 32'd7);
        chk("x0_pop_wd", rf_wd, 32'h77);
        chk("set_wins_busy", {31'b0, busy_rs1}, 32'd1);
        chk("x0_count", {29'b0, fifo_count}, 32'd0);
        aes_issue = 1; aes_issue_rd = 0;
        rs1_q = 0;
        tick();
        aes_issue = 0;
        chk("issue_x0_busy", {31'b0, busy_rs1}, 32'd0);

        // WAW: ALU writes a register with an AES result outstanding.
        chk("waw_clear", {31'b0, err_waw}, 32'd0);
        aes_issue = 1; aes_issue_rd = 12;
        tick();
        aes_issue = 0;
        chk("waw_busy_rs2", {31'b0, busy_rs2}, 32'd1);
        alu_valid = 1; alu_rd = 12; alu_wd = 32'hC;
        tick();
        alu_valid = 0;
        chk("waw_set", {31'b0, err_waw}, 32'd1);
        repeat (3) tick();
        chk("waw_sticky", {31'b0, err_waw}, 32'd1);
        chk("model_waw", {31'b0, exp_err}, 32'd1);
        rst_n = 0;
        #1;
        chk("waw_rst", {31'b0, err_waw}, 32'd0);
        tick();
        rst_n = 1;
        repeat (2) tick();

        cmp_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
